// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - two-requester arbiter and burst read sequencer for the shared ID/key ROM
module rom_access_arbiter #(
  parameter int AW  = 7,
  parameter int DW  = 16,
  parameter int LAT = 1,
  parameter int LW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic [AW-1:0] p_addr,
  input  logic [LW-1:0] p_len,
  output logic          p_gnt,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  output logic          p_done,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  input  logic [LW-1:0] c_len,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_done,
  input  logic          i_force_crypto,
  output logic [AW-1:0] o_A_rom,
  input  logic [DW-1:0] i_Q_rom,
  output logic          o_CEN_rom,
  output logic          o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
  localparam logic SIDE_P = 1'b0;
  localparam logic SIDE_C = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_srv_q, last_srv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          gnt_q, gnt_d;
  logic          win_c;

  logic [LAT-1:0] vld_pipe_q, lst_pipe_q;
  logic           issue, issue_last, cap, cap_last;
  logic           p_rvalid_q, c_rvalid_q, p_done_q, c_done_q;
  logic [DW-1:0]  p_rdata_q, c_rdata_q;

  // The ROM is enabled in exactly the READ cycles, one word per cycle.
  assign issue      = (state_q == S_READ);
  assign issue_last = issue && (cnt_q == len_q);
  assign cap        = vld_pipe_q[LAT-1];
  assign cap_last   = lst_pipe_q[LAT-1];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_srv_d = last_srv_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    gnt_d      = 1'b0;
    win_c      = c_req && (!p_req || i_force_crypto || (last_srv_q == SIDE_P));
    case (state_q)
      S_IDLE: begin
        if (p_req || c_req) begin
          state_d    = S_READ;
          gnt_d      = 1'b1;
          owner_d    = win_c;
          last_srv_d = win_c;
          addr_d     = win_c ? c_addr : p_addr;
          len_d      = win_c ? c_len : p_len;
          cnt_d      = '0;
        end
      end
      S_READ: begin
        if (cnt_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + LW'(1);
        end
      end
      S_DRAIN: begin
        if (p_done_q || c_done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= SIDE_P;
      last_srv_q <= SIDE_C;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      gnt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_srv_q <= last_srv_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      gnt_q      <= gnt_d;
    end
  end

  // Issue tags ride a LAT-deep pipe so capture lines up with the ROM's Q timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
      p_rvalid_q <= 1'b0;
      c_rvalid_q <= 1'b0;
      p_done_q   <= 1'b0;
      c_done_q   <= 1'b0;
      p_rdata_q  <= '0;
      c_rdata_q  <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      lst_pipe_q[0] <= issue_last;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        lst_pipe_q[i] <= lst_pipe_q[i-1];
      end
      p_rvalid_q <= cap && (owner_q == SIDE_P);
      c_rvalid_q <= cap && (owner_q == SIDE_C);
      p_done_q   <= cap && cap_last && (owner_q == SIDE_P);
      c_done_q   <= cap && cap_last && (owner_q == SIDE_C);
      if (cap && (owner_q == SIDE_P)) p_rdata_q <= i_Q_rom;
      if (cap && (owner_q == SIDE_C)) c_rdata_q <= i_Q_rom;
    end
  end

  assign p_gnt     = gnt_q && (owner_q == SIDE_P);
  assign c_gnt     = gnt_q && (owner_q == SIDE_C);
  assign p_rvalid  = p_rvalid_q;
  assign c_rvalid  = c_rvalid_q;
  assign p_rdata   = p_rdata_q;
  assign c_rdata   = c_rdata_q;
  assign p_done    = p_done_q;
  assign c_done    = c_done_q;
  assign o_A_rom   = addr_q;
  assign o_CEN_rom = ~issue;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb/tb_rom_access_arbiter.sv - scoreboard bench for rom_access_arbiter with a LAT=1 ROM model
module tb_rom_access_arbiter;
  localparam int AW  = 7;
  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int LW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, c_req, force_c;
  logic [AW-1:0] p_addr, c_addr;
  logic [LW-1:0] p_len, c_len;
  logic          p_gnt, p_rvalid, p_done, c_gnt, c_rvalid, c_done;
  logic [DW-1:0] p_rdata, c_rdata;
  logic [AW-1:0] o_A_rom;
  logic [DW-1:0] i_Q_rom = '0;
  logic          o_CEN_rom, o_busy;

  rom_access_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_addr(p_addr), .p_len(p_len), .p_gnt(p_gnt),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_done(p_done),
    .c_req(c_req), .c_addr(c_addr), .c_len(c_len), .c_gnt(c_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_done(c_done),
    .i_force_crypto(force_c),
    .o_A_rom(o_A_rom), .i_Q_rom(i_Q_rom), .o_CEN_rom(o_CEN_rom), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: rom[i] = 16'hA000 + i, Q valid one cycle after an enabled edge
  always @(posedge clk) if (o_CEN_rom === 1'b0) i_Q_rom <= 16'hA000 + DW'(o_A_rom);

  typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
  exp_t pq[$];
  exp_t cq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push_burst(input bit side, input logic [AW-1:0] addr, input int len);
    for (int k = 0; k <= len; k++) begin
      exp_t e;
      logic [AW-1:0] a;
      a = addr + AW'(k);
      e.data = 16'hA000 + DW'(a);
      e.last = (k == len);
      if (side) cq.push_back(e); else pq.push_back(e);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; p_req = 1'b0; c_req = 1'b0; force_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pq.delete(); cq.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic collect_grants(output logic [3:0] order, output int n);
    order = '0; n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (p_gnt) begin order[n] = 1'b0; n++; end
      if (c_gnt) begin order[n] = 1'b1; n++; end
    end
    p_req = 1'b0; c_req = 1'b0;
  endtask

  // Scoreboard: every valid word is popped and compared against the expected burst contents.
  always @(negedge clk) begin
    exp_t e;
    if (p_rvalid === 1'b1) begin
      vectors++;
      if (pq.size() == 0) begin
        miscompares++; $display("FAIL p_unexpected_rvalid: rdata=%h expected no valid", p_rdata);
      end else begin
        e = pq.pop_front();
        if (p_rdata !== e.data || p_done !== e.last) begin
          miscompares++;
          $display("FAIL p_word: got rdata=%h done=%b expected rdata=%h done=%b", p_rdata, p_done, e.data, e.last);
        end
      end
    end else if (p_done === 1'b1) begin
      vectors++; miscompares++; $display("FAIL p_done_alone: got done=1 expected 0 without rvalid");
    end
    if (c_rvalid === 1'b1) begin
      vectors++;
      if (cq.size() == 0) begin
        miscompares++; $display("FAIL c_unexpected_rvalid: rdata=%h expected no valid", c_rdata);
      end else begin
        e = cq.pop_front();
        if (c_rdata !== e.data || c_done !== e.last) begin
          miscompares++;
          $display("FAIL c_word: got rdata=%h done=%b expected rdata=%h done=%b", c_rdata, c_done, e.data, e.last);
        end
      end
    end else if (c_done === 1'b1) begin
      vectors++; miscompares++; $display("FAIL c_done_alone: got done=1 expected 0 without rvalid");
    end
  end

  task automatic test_reset;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({p_gnt, p_rvalid, p_done, c_gnt, c_rvalid, c_done} !== 6'b0) begin
      miscompares++; $display("FAIL reset_pulses: got %b expected 000000", {p_gnt, p_rvalid, p_done, c_gnt, c_rvalid, c_done});
    end
    vectors++;
    if (o_CEN_rom !== 1'b1) begin miscompares++; $display("FAIL reset_cen: got %b expected 1", o_CEN_rom); end
    vectors++;
    if (o_A_rom !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", o_A_rom); end
    vectors++;
    if (p_rdata !== '0 || c_rdata !== '0) begin
      miscompares++; $display("FAIL reset_rdata: got p=%h c=%h expected 0 0", p_rdata, c_rdata);
    end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    @(negedge clk);
    p_req = 1'b1; p_addr = 7'd5; p_len = 4'd0;
    push_burst(1'b0, 7'd5, 0);
    @(negedge clk);
    vectors++;
    if (p_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      miscompares++; $display("FAIL single_gnt: got p=%b c=%b expected p=1 c=0", p_gnt, c_gnt);
    end
    vectors++;
    if (o_CEN_rom !== 1'b0 || o_A_rom !== 7'd5) begin
      miscompares++; $display("FAIL single_issue: got cen=%b A=%0d expected cen=0 A=5", o_CEN_rom, o_A_rom);
    end
    p_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (p_rvalid !== 1'b0) begin miscompares++; $display("FAIL single_early: got rvalid=%b expected 0", p_rvalid); end
    @(negedge clk);
    vectors++;
    if (p_rvalid !== 1'b1 || p_done !== 1'b1 || p_rdata !== 16'hA005) begin
      miscompares++;
      $display("FAIL single_data: got v=%b d=%b %h expected v=1 d=1 a005", p_rvalid, p_done, p_rdata);
    end
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a;
    bit ok;
    @(negedge clk);
    c_req = 1'b1; c_addr = 7'd126; c_len = 4'd3;
    push_burst(1'b1, 7'd126, 3);
    @(negedge clk);
    vectors++;
    if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL wrap_gnt: got %b expected 1", c_gnt); end
    c_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      exp_a = 7'd126 + AW'(k);
      vectors++;
      if (o_CEN_rom !== 1'b0 || o_A_rom !== exp_a) begin
        miscompares++;
        $display("FAIL wrap_addr%0d: got cen=%b A=%0d expected cen=0 A=%0d", k, o_CEN_rom, o_A_rom, exp_a);
      end
    end
    @(negedge clk);
    vectors++;
    if (o_CEN_rom !== 1'b1) begin miscompares++; $display("FAIL wrap_drain_cen: got %b expected 1", o_CEN_rom); end
    wait_idle(ok);
    vectors++;
    if (!ok || cq.size() != 0) begin
      miscompares++; $display("FAIL wrap_complete: idle=%b pending=%0d expected idle=1 pending=0", ok, cq.size());
    end
  endtask

  task automatic test_tie;
    int pg, cg, pd, cd;
    bit bad;
    do_reset();
    pg = -1; cg = -1; pd = -1; cd = -1; bad = 1'b0;
    @(negedge clk);
    p_req = 1'b1; c_req = 1'b1; p_addr = 7'd10; c_addr = 7'd20; p_len = 4'd0; c_len = 4'd0;
    push_burst(1'b0, 7'd10, 0);
    push_burst(1'b1, 7'd20, 0);
    for (int i = 0; i < 40 && cd < 0; i++) begin
      @(negedge clk);
      if (p_gnt) begin pg = cyc; p_req = 1'b0; end
      if (c_gnt) begin cg = cyc; c_req = 1'b0; end
      if (p_done) pd = cyc;
      if (cg >= 0 && p_rvalid) bad = 1'b1;
      if (c_done) cd = cyc;
    end
    vectors++;
    if (pg < 0 || cg < 0 || pg >= cg) begin
      miscompares++; $display("FAIL tie_order: got p_gnt@%0d c_gnt@%0d expected protocol first", pg, cg);
    end
    vectors++;
    if (pd < 0 || cg <= pd || cg > pd + 2) begin
      miscompares++; $display("FAIL tie_next_gnt: got c_gnt@%0d p_done@%0d expected c_gnt just after p_done", cg, pd);
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL tie_p_rvalid: got p_rvalid=1 during crypto burst expected 0"); end
    vectors++;
    if (cd < 0) begin miscompares++; $display("FAIL tie_timeout: got no c_done expected one"); end
  endtask

  task automatic test_round_robin;
    logic [3:0] order;
    int n;
    bit ok;
    @(negedge clk);
    p_addr = 7'd30; c_addr = 7'd40; p_len = 4'd1; c_len = 4'd1;
    push_burst(1'b0, 7'd30, 1); push_burst(1'b1, 7'd40, 1);
    push_burst(1'b0, 7'd30, 1); push_burst(1'b1, 7'd40, 1);
    p_req = 1'b1; c_req = 1'b1;
    collect_grants(order, n);
    vectors++;
    if (n != 4 || order !== 4'b1010) begin
      miscompares++; $display("FAIL rr_order: got n=%0d order=%b expected n=4 order=1010", n, order);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_idle: got busy expected idle"); end
    force_c = 1'b1; c_addr = 7'd70; c_len = 4'd0;
    for (int i = 0; i < 4; i++) push_burst(1'b1, 7'd70, 0);
    p_req = 1'b1; c_req = 1'b1;
    collect_grants(order, n);
    vectors++;
    if (n != 4 || order !== 4'b1111) begin
      miscompares++; $display("FAIL force_order: got n=%0d order=%b expected n=4 order=1111", n, order);
    end
    wait_idle(ok);
    force_c = 1'b0;
    vectors++;
    if (!ok || pq.size() != 0 || cq.size() != 0) begin
      miscompares++; $display("FAIL rr_complete: idle=%b pend p=%0d c=%0d expected 1 0 0", ok, pq.size(), cq.size());
    end
  endtask

  task automatic test_reset_mid;
    bit seen, got, ok;
    @(negedge clk);
    p_req = 1'b1; p_addr = 7'd50; p_len = 4'd7;
    @(negedge clk);
    vectors++;
    if (p_gnt !== 1'b1) begin miscompares++; $display("FAIL rstmid_gnt: got %b expected 1", p_gnt); end
    p_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_CEN_rom !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_abort: got cen=%b busy=%b expected cen=1 busy=0", o_CEN_rom, o_busy);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p_rvalid || p_done) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL rstmid_flush: got rvalid/done after reset expected none"); end
    p_req = 1'b1; p_addr = 7'd0; p_len = 4'd2;
    push_burst(1'b0, 7'd0, 2);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (p_gnt) got = 1'b1;
    end
    p_req = 1'b0;
    vectors++;
    if (!got) begin miscompares++; $display("FAIL rstmid_regrant: got no p_gnt expected one"); end
    wait_idle(ok);
    vectors++;
    if (!ok || pq.size() != 0) begin
      miscompares++; $display("FAIL rstmid_complete: idle=%b pending=%0d expected 1 0", ok, pq.size());
    end
  endtask

  task automatic test_withdraw;
    bit seen, ok;
    @(negedge clk);
    c_req = 1'b1; c_addr = 7'd60; c_len = 4'd3;
    push_burst(1'b1, 7'd60, 3);
    @(negedge clk);
    vectors++;
    if (c_gnt !== 1'b1) begin miscompares++; $display("FAIL withdraw_cgnt: got %b expected 1", c_gnt); end
    c_req = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    p_req = 1'b1; p_addr = 7'd1; p_len = 4'd0;
    @(negedge clk);
    if (p_gnt) seen = 1'b1;
    p_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (p_gnt) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL withdraw_pgnt: got p_gnt=1 expected never"); end
    wait_idle(ok);
    vectors++;
    if (!ok || pq.size() != 0 || cq.size() != 0) begin
      miscompares++; $display("FAIL withdraw_complete: idle=%b pend p=%0d c=%0d expected 1 0 0", ok, pq.size(), cq.size());
    end
  endtask

  initial begin
    rst = 1'b1; p_req = 1'b0; c_req = 1'b0; force_c = 1'b0;
    p_addr = '0; c_addr = '0; p_len = '0; c_len = '0;
    test_reset();
    test_single();
    test_wrap();
    test_tie();
    test_round_robin();
    test_reset_mid();
    test_withdraw();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
